// File: rtl/mdu_iter_pkg.sv
// Shared opcode and FSM encodings for the iterative multiply/divide unit.
package mdu_iter_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_div_core.sv
// Radix-2 restoring divider: one quotient bit per cycle, WIDTH cycles starting on the start edge.
module mdu_iter_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             running;

    logic [WIDTH-1:0] r_src;
    logic [WIDTH-1:0] q_src;
    logic [WIDTH-1:0] d_src;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The start edge performs the first iteration directly from the input operands.
    always_comb begin
        r_src   = start ? '0 : rem;
        q_src   = start ? dividend : quot;
        d_src   = start ? divisor : dsr;
        shifted = {r_src, q_src[WIDTH-1]};
        trial   = shifted - {1'b0, d_src};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsr     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
        end else if (flush) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start || running) begin
            quot <= {q_src[WIDTH-2:0], ~trial[WIDTH]};
            rem  <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            if (start) begin
                dsr     <= divisor;
                cnt     <= CW'(1);
                running <= 1'b1;
                done    <= 1'b0;
            end else if (cnt == CW'(WIDTH - 1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Optional MDU_CANCEL_EN adds a cancel port that flushes an in-flight operation.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
`ifdef MDU_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int unsigned PW  = 2 * WIDTH;

    mdu_state_e       state;
    logic [MCW-1:0]   mul_cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             is_signed;

    logic             abort_c;
    logic             div_start_c;
    logic             div_signed_c;
    logic [WIDTH-1:0] div_a_c;
    logic [WIDTH-1:0] div_b_c;
    logic [PW-1:0]    ext_a;
    logic [PW-1:0]    ext_b;
    logic [PW-1:0]    product;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;
    logic             div_done;
    logic             q_neg;
    logic             r_neg;

`ifdef MDU_CANCEL_EN
    assign abort_c = cancel & busy;
`else
    assign abort_c = 1'b0;
`endif

    // Divider operand preparation happens on the accept cycle so the core starts immediately.
    always_comb begin
        div_signed_c = (md_op == MD_DIV);
        div_start_c  = (state == ST_IDLE) && md_start && (md_op == MD_DIV || md_op == MD_DIVU);
        div_a_c      = (div_signed_c && src_a[WIDTH-1]) ? -src_a : src_a;
        div_b_c      = (div_signed_c && src_b[WIDTH-1]) ? -src_b : src_b;
        ext_a        = {{WIDTH{is_signed & opa[WIDTH-1]}}, opa};
        ext_b        = {{WIDTH{is_signed & opb[WIDTH-1]}}, opb};
        product      = ext_a * ext_b;
        q_neg        = is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_neg        = is_signed & opa[WIDTH-1];
    end

    mdu_iter_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start_c),
        .flush    (abort_c),
        .dividend (div_a_c),
        .divisor  (div_b_c),
        .quot     (div_quot),
        .rem      (div_rem),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mul_cnt   <= '0;
            opa       <= '0;
            opb       <= '0;
            is_signed <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            if (abort_c) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (md_start) begin
                            case (md_op)
                                MD_MULT, MD_MULTU: begin
                                    opa       <= src_a;
                                    opb       <= src_b;
                                    is_signed <= (md_op == MD_MULT);
                                    mul_cnt   <= '0;
                                    busy      <= 1'b1;
                                    state     <= ST_MUL;
                                end
                                MD_DIV, MD_DIVU: begin
                                    opa       <= src_a;
                                    opb       <= src_b;
                                    is_signed <= div_signed_c;
                                    busy      <= 1'b1;
                                    state     <= ST_DIV;
                                end
                                MD_MTHI: hi <= src_a;
                                MD_MTLO: lo <= src_a;
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (mul_cnt == MCW'(MUL_CYCLES - 1)) begin
                            {hi, lo} <= product;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            mul_cnt <= mul_cnt + MCW'(1);
                        end
                    end
                    ST_DIV: begin
                        if (div_done) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        // Divide by zero reports the raw dividend; otherwise apply result signs.
                        if (opb == '0) begin
                            hi <= opa;
                            lo <= '1;
                        end else begin
                            hi <= r_neg ? -div_rem : div_rem;
                            lo <= q_neg ? -div_quot : div_quot;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32, MUL_CYCLES=5); define MDU_CANCEL_EN to also test cancel.
module tb_mdu_iter;

    logic        clk;
    logic        reset_n;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;
    logic [63:0] sb[$];

    mdu_iter #(
        .WIDTH      (32),
        .MUL_CYCLES (5)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .md_start (md_start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
`ifdef MDU_CANCEL_EN
        .cancel   (cancel),
`endif
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                check("result", {hi, lo}, sb.pop_front());
            end
        end
    end

    // Issue at a negedge, scramble operands while busy, wait for busy to drop.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy, input logic [63:0] exp_res,
                          input bit push);
        int cycles;
        bit held;
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        md_start = 1'b1;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        if (push) sb.push_back(exp_res);
        @(negedge clk);
        md_start = 1'b0;
        src_a    = ~a;
        src_b    = b + 32'd3;
        cycles   = 0;
        held     = 1'b1;
        while (busy && cycles < 200) begin
            if (hi !== h0 || lo !== l0) held = 1'b0;
            cycles++;
            @(negedge clk);
        end
        check({name, "_busy"}, 64'(cycles), 64'(exp_busy));
        if (exp_busy > 0) check({name, "_hold"}, 64'(held), 64'd1);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        md_start = 1'b0;
        md_op    = 3'd0;
        src_a    = '0;
        src_b    = '0;
        cancel   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {30'd0, busy, done, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mult_neg",   3'd0, 32'hFFFF_FFFD, 32'd7,        5,  64'hFFFF_FFFF_FFFF_FFEB, 1);
        run_op("multu_max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001, 1);
        run_op("mult_pos",   3'd0, 32'h1234_5678, 32'h10,       5,  64'h0000_0001_2345_6780, 1);
        run_op("mult_min",   3'd0, 32'h8000_0000, 32'h8000_0000, 5, 64'h4000_0000_0000_0000, 1);
        run_op("div_neg_a",  3'd2, 32'hFFFF_FFF9, 32'd2,        33, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        run_op("div_neg_b",  3'd2, 32'd7,         32'hFFFF_FFFE, 33, 64'h0000_0001_FFFF_FFFD, 1);
        run_op("div_100_7",  3'd2, 32'd100,       32'd7,        33, 64'h0000_0002_0000_000E, 1);
        run_op("divu_big",   3'd3, 32'hFFFF_FFFF, 32'h10,       33, 64'h0000_000F_0FFF_FFFF, 1);
        run_op("divu_zero",  3'd3, 32'd5,         32'd0,        33, 64'h0000_0005_FFFF_FFFF, 1);
        run_op("div_zero",   3'd2, 32'hFFFF_FFFB, 32'd0,        33, 64'hFFFF_FFFB_FFFF_FFFF, 1);
        run_op("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000, 1);

        // DIVU 7/2 with an MTHI attempted while busy; the MTHI must be dropped.
        md_start = 1'b1; md_op = 3'd3; src_a = 32'd7; src_b = 32'd2;
        sb.push_back(64'h0000_0001_0000_0003);
        @(negedge clk);
        md_op = 3'd4; src_a = 32'h1234; src_b = '0;
        @(negedge clk);
        md_start = 1'b0;
        check("mthi_busy_ignored", {32'd0, hi}, {32'd0, 32'h0000_0000});
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("divu_7_2_hi", {32'd0, hi}, 64'd1);

        run_op("mtlo", 3'd5, 32'hABCD, 32'd0, 0, 64'd0, 0);
        check("mtlo_val", {31'd0, busy, lo}, 64'h0000_ABCD);
        run_op("reserved", 3'd6, 32'hDEAD, 32'd0, 0, 64'd0, 0);
        check("reserved_noop", {hi, lo}, 64'h0000_0001_0000_ABCD);

        // Asynchronous reset in the middle of a divide.
        md_start = 1'b1; md_op = 3'd2; src_a = 32'd50; src_b = 32'd3;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("mid_reset", {31'd0, busy, hi}, 64'd0);
        check("mid_reset_lo", {31'd0, done, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_idle", {31'd0, busy, lo}, 64'd0);

`ifdef MDU_CANCEL_EN
        run_op("mthi55", 3'd4, 32'h55, 32'd0, 0, 64'd0, 0);
        run_op("mtlo55", 3'd5, 32'h55, 32'd0, 0, 64'd0, 0);
        md_start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        md_start = 1'b0;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy, 32'd0}, 64'd0);
        repeat (8) @(negedge clk);
        check("cancel_hilo", {hi, lo}, 64'h0000_0055_0000_0055);
        run_op("after_cancel", 3'd3, 32'd9, 32'd4, 33, 64'h0000_0001_0000_0002, 1);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
